// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
// Shared types and helpers for the UART transmitter slice.
//   tx_state_e : serializer FSM states (PARITY only reachable when
//                UART_TX_PARITY_EN is defined)
//   DATA_BITS  : payload bits per frame
//   clamp_div  : maps a divisor of 0 to 1 so every bit lasts >= 1 cycle
package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   localparam int DATA_BITS = 8;

   function automatic logic [31:0] clamp_div(input logic [31:0] div);
      return (div == 32'd0) ? 32'd1 : div;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// DEPTH x WIDTH synchronous FIFO with occupancy count.
//   clk_i, rst_ni : clock, synchronous active-low reset (empties the FIFO)
//   push_i        : write wdata_i (caller only pushes when !full_o)
//   pop_i         : advance read pointer (caller only pops when !empty_o)
//   wdata_i       : write data
//   rdata_o       : head entry, valid while !empty_o
//   full_o        : level_o == DEPTH
//   empty_o       : level_o == 0
//   level_o       : current occupancy, 0..DEPTH
module uart_tx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [WIDTH-1:0]       wdata_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [LW-1:0]    level_q;

   // Pointers are exactly AW bits, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_i, pop_i})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // Storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;

endmodule

// File: rtl/uart_tx_fifo_ser.sv
// uart_tx_fifo_ser
// Buffered UART transmitter: bytes enter over valid/ready into a FIFO and
// leave LSB-first as 8N1 frames (8E1 when UART_TX_PARITY_EN is defined)
// at div_i clocks per bit.
//   clk_i, rst_ni : clock, synchronous active-low reset (aborts any frame)
//   data_i        : byte to send
//   valid_i       : data_i valid
//   ready_o       : FIFO not full
//   div_i         : clocks per bit, 0 behaves as 1, latched at frame start
//   tx_o          : serial line, idle high
//   busy_o        : frame in progress or bytes buffered
//   level_o       : FIFO occupancy
// Handshake: a byte is taken on every rising edge where valid_i && ready_o;
// ready_o does not depend on valid_i, and a pop in a full cycle does not
// free a slot until the following cycle.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit.
module uart_tx_fifo_ser
   import uart_tx_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int DIV_W = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [7:0]             data_i,
   input  logic                   valid_i,
   output logic                   ready_o,
   input  logic [DIV_W-1:0]       div_i,
   output logic                   tx_o,
   output logic                   busy_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int LW = $clog2(DEPTH) + 1;

   logic                 fifo_full;
   logic                 fifo_empty;
   logic [7:0]           fifo_rdata;
   logic [LW-1:0]        fifo_level;
   logic                 push;
   logic                 pop;
   logic                 bit_end;
   logic [DIV_W-1:0]     eff_div;

   tx_state_e            state_q;
   logic [DIV_W-1:0]     div_q;
   logic [DIV_W-1:0]     cnt_q;
   logic [2:0]           bit_cnt_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 tx_q;
`ifdef UART_TX_PARITY_EN
   logic                 par_q;
`endif

   uart_tx_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (data_i),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign ready_o = ~fifo_full;
   assign push    = valid_i & ~fifo_full;
   assign eff_div = DIV_W'(clamp_div(32'(div_i)));
   assign bit_end = (cnt_q == '0);

   // A byte is taken either from idle or at the very end of a stop bit,
   // which is what makes queued frames run back-to-back.
   assign pop = ~fifo_empty &
                ((state_q == IDLE) | ((state_q == STOP) & bit_end));

   // tx_q is the registered line level of the current state, so the line
   // trails the FSM by one cycle; every bit still lasts eff_div cycles.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         div_q     <= DIV_W'(1);
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               tx_q <= 1'b1;
            end
            START: begin
               tx_q <= 1'b0;
               if (bit_end) begin
                  cnt_q     <= div_q - DIV_W'(1);
                  bit_cnt_q <= '0;
                  state_q   <= DATA;
               end else begin
                  cnt_q <= cnt_q - DIV_W'(1);
               end
            end
            DATA: begin
               tx_q <= shift_q[0];
               if (bit_end) begin
                  cnt_q   <= div_q - DIV_W'(1);
                  shift_q <= shift_q >> 1;
                  if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                     state_q <= PARITY;
`else
                     state_q <= STOP;
`endif
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_q - DIV_W'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               tx_q <= par_q;
               if (bit_end) begin
                  cnt_q   <= div_q - DIV_W'(1);
                  state_q <= STOP;
               end else begin
                  cnt_q <= cnt_q - DIV_W'(1);
               end
            end
`endif
            STOP: begin
               tx_q <= 1'b1;
               if (bit_end) begin
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - DIV_W'(1);
               end
            end
            default: begin
               tx_q    <= 1'b1;
               state_q <= IDLE;
            end
         endcase

         // Frame start; placed last so it overrides the STOP->IDLE move.
         if (pop) begin
            shift_q <= fifo_rdata;
            div_q   <= eff_div;
            cnt_q   <= eff_div - DIV_W'(1);
            state_q <= START;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^fifo_rdata;
`endif
         end
      end
   end

   assign tx_o    = tx_q;
   assign busy_o  = (state_q != IDLE) | (fifo_level != '0);
   assign level_o = fifo_level;

endmodule

// File: tb/tb_uart_tx_fifo_ser.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo_ser;

  localparam int DEPTH = 8;
  localparam int DIV_W = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int BAUD  = 28;
`ifdef UART_TX_PARITY_EN
  localparam int FLEN = 11;
`else
  localparam int FLEN = 10;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic             clk_i   = 1'b0;
  logic             rst_ni  = 1'b0;
  logic [7:0]       data_i  = 8'h00;
  logic             valid_i = 1'b0;
  logic [DIV_W-1:0] div_i   = DIV_W'(BAUD);
  logic             ready_o;
  logic             tx_o;
  logic             busy_o;
  logic [LW-1:0]    level_o;

  always #10 clk_i = ~clk_i;  // 50 MHz

  uart_tx_fifo_ser #(
    .DEPTH (DEPTH),
    .DIV_W (DIV_W)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .div_i   (div_i),
    .tx_o    (tx_o),
    .busy_o  (busy_o),
    .level_o (level_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Schedule view: a byte accepted at edge N is taken by the serializer at
  // edge max(N+1, end of previous frame); the line goes low one edge later
  // and each of the FLEN bits lasts d = max(div,1) cycles.
  typedef struct {
    int         n;
    logic [7:0] b;
  } ent_t;

  ent_t       mq[$];
  int         cyc     = 0;
  int         free_at = 0;
  bit         cur_v   = 1'b0;
  bit         prev_v  = 1'b0;
  int         cur_p   = 0, cur_d = 1, prev_p = 0, prev_d = 1;
  logic [7:0] cur_b   = 8'h00, prev_b = 8'h00;
  logic       exp_tx  = 1'b1, exp_busy = 1'b0, exp_ready = 1'b1;
  int         exp_level = 0;
  int         m_sz;
  bit         m_acc;

  function automatic logic line_bit(int p, int d, logic [7:0] b, int k);
    int idx;
    if (k < p + 1 || k > p + FLEN * d) return 1'b1;
    idx = (k - p - 1) / d;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  always @(posedge clk_i) begin
    cyc = cyc + 1;
    if (!rst_ni) begin
      mq.delete();
      cur_v   = 1'b0;
      prev_v  = 1'b0;
      free_at = 0;
    end else begin
      m_sz  = mq.size();
      m_acc = valid_i && (m_sz != DEPTH);
      if (m_sz > 0 && cyc >= mq[0].n + 1 && cyc >= free_at) begin
        prev_v = cur_v; prev_p = cur_p; prev_d = cur_d; prev_b = cur_b;
        cur_v  = 1'b1;
        cur_p  = cyc;
        cur_b  = mq[0].b;
        cur_d  = (div_i == '0) ? 1 : int'(div_i);
        void'(mq.pop_front());
        free_at = cyc + FLEN * cur_d;
      end
      if (m_acc) mq.push_back('{n: cyc, b: data_i});
    end
    exp_level = mq.size();
    exp_ready = (mq.size() != DEPTH);
    exp_busy  = (mq.size() != 0) || (cur_v && cyc < cur_p + FLEN * cur_d);
    if (cur_v && cyc >= cur_p + 1)
      exp_tx = line_bit(cur_p, cur_d, cur_b, cyc);
    else if (prev_v)
      exp_tx = line_bit(prev_p, prev_d, prev_b, cyc);
    else
      exp_tx = 1'b1;
  end

  // ---------------- per-cycle compare ----------------
  bit chk_en = 1'b0;
  int peak   = 0;

  always @(negedge clk_i) begin
    if (chk_en) begin
      check("cyc_tx_o",    int'(tx_o),    int'(exp_tx));
      check("cyc_busy_o",  int'(busy_o),  int'(exp_busy));
      check("cyc_ready_o", int'(ready_o), int'(exp_ready));
      check("cyc_level_o", int'(level_o), exp_level);
      if (int'(level_o) > peak) peak = int'(level_o);
    end
  end

  // ---------------- line receiver + scoreboard ----------------
  logic [7:0] exp_q[$];
  bit         rx_en  = 1'b0;
  logic [7:0] rx_b;

  always begin
    @(negedge clk_i);
    if (rx_en && rst_ni && tx_o === 1'b0) begin
      repeat (BAUD / 2) @(negedge clk_i);
      check("rx_start_bit", int'(tx_o), 0);
      for (int i = 0; i < 8; i++) begin
        repeat (BAUD) @(negedge clk_i);
        rx_b[i] = tx_o;
      end
`ifdef UART_TX_PARITY_EN
      repeat (BAUD) @(negedge clk_i);
      check("rx_parity", int'((^rx_b) ^ tx_o), 0);
`endif
      repeat (BAUD) @(negedge clk_i);
      check("rx_stop_bit", int'(tx_o), 1);
      check("rx_byte_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("rx_byte", int'(rx_b), int'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  bit saw_stall = 1'b0;

  // Entered and left on a falling edge; hs = edge that took the byte.
  task automatic push_byte(input logic [7:0] b, output int hs);
    int n;
    n = 0;
    data_i  = b;
    valid_i = 1'b1;
    while (ready_o !== 1'b1 && n < 5000) begin
      saw_stall = 1'b1;
      @(negedge clk_i);
      n++;
    end
    check("push_timeout", int'(n < 5000), 1);
    hs = cyc + 1;
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, output int at);
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < 20000) begin
      @(negedge clk_i);
      n++;
    end
    check({name, "_idle_timeout"}, int'(n < 20000), 1);
    at = cyc;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int h0, h, t, n;
    logic [7:0] v;

    // T1: reset state
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_tx_o",    int'(tx_o),    1);
    check("rst_ready_o", int'(ready_o), 1);
    check("rst_busy_o",  int'(busy_o),  0);
    check("rst_level_o", int'(level_o), 0);
    rst_ni = 1'b1;
    chk_en = 1'b1;
    @(negedge clk_i);

    // T2: single 'A'; div change mid-frame must not stretch this frame
    rx_en = 1'b1;
    exp_q.push_back(8'h41);
    push_byte(8'h41, h0);
    @(negedge clk_i);
    check("t2_tx_high_n1", int'(tx_o), 1);
    div_i = DIV_W'(5);
    @(negedge clk_i);
    check("t2_tx_low_n2", int'(tx_o), 0);
    n = 0;
    while (tx_o === 1'b0 && n < 1000) begin
      n++;
      @(negedge clk_i);
    end
    check("t2_start_len", n, 28);
    wait_idle("t2", t);
    check("t2_frame_span", t - h0, FLEN * 28 + 1);
    check("t2_rx_left", exp_q.size(), 0);
    div_i = DIV_W'(BAUD);

    // T3: "Hi\n" back-to-back
    peak = 0;
    exp_q.push_back(8'h48); exp_q.push_back(8'h69); exp_q.push_back(8'h0A);
    push_byte(8'h48, h0);
    push_byte(8'h69, h);
    push_byte(8'h0A, h);
    check("t3_gapless_push", h - h0, 2);
    wait_idle("t3", t);
    check("t3_span", t - h0, 3 * FLEN * 28 + 1);
    check("t3_level_peak", peak, 2);
    check("t3_rx_left", exp_q.size(), 0);

    // T4: ten bytes without gaps; FIFO fills, tenth waits for a pop
    peak = 0;
    saw_stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      v = 8'(8'h30 + i);
      exp_q.push_back(v);
      push_byte(v, h);
      if (i == 0) h0 = h;
    end
    check("t4_stall_seen", int'(saw_stall), 1);
    check("t4_tenth_accept", h - h0, FLEN * 28 + 2);
    wait_idle("t4", t);
    check("t4_span", t - h0, 10 * FLEN * 28 + 1);
    check("t4_level_peak", peak, 8);
    check("t4_rx_left", exp_q.size(), 0);

    // T5: reset in the middle of 0x55 with 0x66 still buffered
    rx_en = 1'b0;
    push_byte(8'h55, h0);
    push_byte(8'h66, h);
    while (cyc < h0 + 2 + 28 * 4) @(negedge clk_i);
    check("t5_busy_before", int'(busy_o), 1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("t5_rst_tx_o",    int'(tx_o),    1);
    check("t5_rst_level_o", int'(level_o), 0);
    check("t5_rst_busy_o",  int'(busy_o),  0);
    check("t5_rst_ready_o", int'(ready_o), 1);
    rst_ni = 1'b1;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1) n++;
    end
    check("t5_line_quiet", n, 0);
    rx_en = 1'b1;
    exp_q.push_back(8'h33);
    push_byte(8'h33, h0);
    wait_idle("t5", t);
    check("t5_rx_left", exp_q.size(), 0);

    // T6: div_i = 0 behaves as one-cycle bits, 0xA5 -> 0,1,0,1,0,...
    rx_en = 1'b0;
    div_i = '0;
    push_byte(8'hA5, h0);
    @(negedge clk_i);
    @(negedge clk_i);
    check("t6_start", int'(tx_o), 0);
    @(negedge clk_i);
    check("t6_bit0", int'(tx_o), 1);
    @(negedge clk_i);
    check("t6_bit1", int'(tx_o), 0);
    wait_idle("t6", t);
    check("t6_span", t - h0, FLEN + 1);
    div_i = DIV_W'(BAUD);

`ifdef UART_TX_PARITY_EN
    // T7: 0x07 has three ones, so the even-parity bit is 1; 11-bit frame
    rx_en = 1'b1;
    exp_q.push_back(8'h07);
    push_byte(8'h07, h0);
    while (cyc < h0 + 2 + 9 * 28 + 14) @(negedge clk_i);
    check("t7_parity_bit", int'(tx_o), 1);
    wait_idle("t7", t);
    check("t7_span", t - h0, 309);
    check("t7_rx_left", exp_q.size(), 0);
`endif

    repeat (5) @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
